mult_arbiter: RTL and testbench

Shares one pipelined array multiplier among NUM_REQ requesters. Round-robin arbitration issues at most one product per cycle; a tag pipeline matched to the multiplier latency carries the requester ID alongside each operation; a credit-guarded result FIFO returns products on a single ready/valid response port. Sits between client blocks and the `array_multiplier` instance, driving its `i_valid`/`A`/`B` and consuming `o_valid`/`Z_final`.

---
 rtl/mult_arbiter_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/mult_arbiter.sv | 138 +++++++++++++
 tb/tb_mult_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter: ID sizing, response entry, round-robin pick.
package mult_arbiter_pkg;

  localparam int ID_W_MAX = 4;
  localparam int Z_W_MAX  = 64;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [Z_W_MAX-1:0]  z;
  } rsp_entry_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {found, index}; the search starts one past 'last' and wraps at n.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid, input logic [3:0] last,
                                         input int n);
    logic       found;
    logic [3:0] idx;
    int         c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k <= n && !found) begin
        c = (int'(last) + k) % n;
        if (valid[c[3:0]]) begin
          found = 1'b1;
          idx   = c[3:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with count-based status; read data is zero while empty.
// Push when full is dropped and flagged on overflow_o unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop        = rd_en_i && !empty_o;
  assign push       = wr_en_i && (!full || pop);
  assign overflow_o = wr_en_i && !push;
  assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin share of one pipelined multiplier; handshake-to-response latency MULT_LATENCY+2.
// Credits cap issued-but-unpopped ops at FIFO_DEPTH, so rsp_ready low stalls issue once the FIFO is committed.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 4,
  parameter int FIFO_DEPTH   = 8,
  localparam int ID_W        = id_width(NUM_REQ),
  localparam int ZW          = 2 * DATAWIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  output logic                         mult_i_valid,
  output logic [DATAWIDTH-1:0]         mult_a,
  output logic [DATAWIDTH-1:0]         mult_b,
  input  logic                         mult_o_valid,
  input  logic [ZW-1:0]                mult_z,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [ZW-1:0]                rsp_z,
  output logic                         err_desync
);

  localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
  localparam int L     = MULT_LATENCY;

  logic                 run_q;
  logic [CRD_W-1:0]     credits_q, credits_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic                 mult_vld_q, mult_vld_d;
  logic [DATAWIDTH-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [ID_W-1:0]      issue_id_q, issue_id_d;
  logic [L-1:0]         tag_vld_q;
  logic [ID_W-1:0]      tag_id_q [L];
  logic                 err_q, err_d;

  logic [4:0]           pick;
  logic                 win_found, grant, pop, fifo_empty, fifo_ovf;
  logic [ID_W-1:0]      win_idx;
  rsp_entry_t           wr_ent, rd_ent;
  logic                 unused_rd;

  // run_q holds off grants for the first cycle so req_ready is low throughout reset.
  assign pick      = rr_pick(16'(req_valid), 4'(last_q), NUM_REQ);
  assign win_found = pick[4];
  assign win_idx   = pick[ID_W-1:0];
  assign grant     = run_q && win_found && (credits_q != '0);
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign pop       = !fifo_empty && rsp_ready;

  always_comb begin
    last_d     = grant ? win_idx : last_q;
    mult_vld_d = grant;
    mult_a_d   = grant ? req_a[int'(win_idx)*DATAWIDTH +: DATAWIDTH] : '0;
    mult_b_d   = grant ? req_b[int'(win_idx)*DATAWIDTH +: DATAWIDTH] : '0;
    issue_id_d = grant ? win_idx : '0;
    case ({grant, pop})
      2'b10:   credits_d = credits_q - CRD_W'(1);
      2'b01:   credits_d = credits_q + CRD_W'(1);
      default: credits_d = credits_q;
    endcase
    err_d = err_q | (tag_vld_q[L-1] != mult_o_valid) | fifo_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      credits_q  <= CRD_W'(FIFO_DEPTH);
      last_q     <= ID_W'(NUM_REQ - 1);
      mult_vld_q <= 1'b0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      issue_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      credits_q  <= credits_d;
      last_q     <= last_d;
      mult_vld_q <= mult_vld_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      issue_id_q <= issue_id_d;
      err_q      <= err_d;
    end
  end

  // Tag stage k is aligned with the multiplier's internal stage k; the last one meets mult_o_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int k = 0; k < L; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= mult_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < L; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  always_comb begin
    wr_ent    = '0;
    wr_ent.id = ID_W_MAX'(tag_id_q[L-1]);
    wr_ent.z  = Z_W_MAX'(mult_z);
  end

  sync_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (tag_vld_q[L-1]),
    .wr_data_i (wr_ent),
    .rd_en_i   (rsp_ready),
    .rd_data_o (rd_ent),
    .empty_o   (fifo_empty),
    .overflow_o(fifo_ovf)
  );

  assign unused_rd    = ^{rd_ent.id, rd_ent.z};
  assign mult_i_valid = mult_vld_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign rsp_valid    = !fifo_empty;
  assign rsp_id       = rd_ent.id[ID_W-1:0];
  assign rsp_z        = rd_ent.z[ZW-1:0];
  assign err_desync   = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural 4-stage multiplier and a response scoreboard.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        mult_i_valid, mult_o_valid;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_z;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_z;
  logic        err_desync;

  logic [7:0]  a_v [4];
  logic [7:0]  b_v [4];
  logic        inj;
  logic [3:0]  mv_q;
  logic [15:0] mz_q [4];

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int last_z = 0;
  int seen;
  int exp_id [$];
  int exp_z  [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a_v[i];
      req_b[i*8 +: 8] = b_v[i];
    end
  end

  // Behavioural multiplier: four register stages, product computed at entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_q <= '0;
      for (int k = 0; k < 4; k++) mz_q[k] <= '0;
    end else begin
      mv_q    <= {mv_q[2:0], mult_i_valid};
      mz_q[0] <= 16'(mult_a) * 16'(mult_b);
      for (int k = 1; k < 4; k++) mz_q[k] <= mz_q[k-1];
    end
  end
  assign mult_o_valid = mv_q[3] | inj;
  assign mult_z       = mz_q[3];

  mult_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mult_i_valid(mult_i_valid),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_o_valid(mult_o_valid),
    .mult_z      (mult_z),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_z       (rsp_z),
    .err_desync  (err_desync)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: record accepted requests, score any popped response, advance to edge+1.
  task automatic cycle();
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        exp_id.push_back(i);
        exp_z.push_back(int'(a_v[i]) * int'(b_v[i]));
        accepts++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      check("rsp_expected", 32'(exp_id.size() > 0), 1);
      if (exp_id.size() > 0) begin
        check("rsp_id", 32'(rsp_id), exp_id.pop_front());
        check("rsp_z", 32'(rsp_z), exp_z.pop_front());
        last_z = int'(rsp_z);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    inj = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'(10 + i);
      b_v[i] = 8'(20 + i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_mult_i_valid", 32'(mult_i_valid), 0);
    check("reset_mult_a", 32'(mult_a), 0);
    check("reset_mult_b", 32'(mult_b), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_z", 32'(rsp_z), 0);
    check("reset_err", 32'(err_desync), 0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    cycle();

    // Single request from requester 2: response exactly 6 cycles after handshake.
    a_v[2] = 8'd13;
    b_v[2] = 8'd11;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    cycle();
    req_valid = 4'h0;
    #1;
    check("single_issue_vld", 32'(mult_i_valid), 1);
    check("single_issue_a", 32'(mult_a), 13);
    check("single_issue_b", 32'(mult_b), 11);
    check("single_early_rsp", 32'(rsp_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("single_early_rsp", 32'(rsp_valid), 0);
    end
    cycle();
    check("single_rsp_valid", 32'(rsp_valid), 1);
    check("single_rsp_id", 32'(rsp_id), 2);
    check("single_rsp_z", 32'(rsp_z), 143);
    cycle();

    // All four streaming: last grant was 2, so grants rotate 3,0,1,2,...; responses back-to-back.
    a_v[2] = 8'd12;
    b_v[2] = 8'd22;
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req_valid = 4'h0;
      #1;
      if (c < 8) check("rr_grant", 32'(req_ready), 32'(1) << ((3 + c) % 4));
      check("rr_rsp_valid", 32'(rsp_valid), 32'((c >= 6) && (c < 14)));
      cycle();
    end

    // Consumer stalled: exactly FIFO_DEPTH accepts, then one pop frees one issue.
    rsp_ready = 1'b0;
    a_v[0] = 8'd3;
    b_v[0] = 8'd5;
    req_valid = 4'b0001;
    accepts = 0;
    repeat (20) cycle();
    check("stall_accepts", 32'(accepts), 8);
    #1;
    check("stall_ready_low", 32'(req_ready), 0);
    check("stall_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    #1;
    check("reopen_ready", 32'(req_ready), 1);
    cycle();
    #1;
    check("reopen_closed", 32'(req_ready), 0);
    check("reopen_accepts", 32'(accepts), 9);

    // Pop and issue together around zero credits, then drain.
    a_v[0] = 8'd255;
    b_v[0] = 8'd255;
    rsp_ready = 1'b1;
    repeat (30) cycle();
    req_valid = 4'h0;
    repeat (16) cycle();
    check("boundary_err", 32'(err_desync), 0);
    check("boundary_drained", 32'(exp_id.size()), 0);
    check("boundary_rsp_valid", 32'(rsp_valid), 0);
    check("boundary_last_z", 32'(last_z), 65025);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    accepts = 0;
    repeat (16) cycle();
    check("credits_restored", 32'(accepts), 8);
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    repeat (16) cycle();
    check("credits_drained", 32'(exp_id.size()), 0);
    check("credits_err", 32'(err_desync), 0);

    // Spurious multiplier valid with no tag in flight.
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    #1;
    check("desync_set", 32'(err_desync), 1);
    check("desync_no_write", 32'(rsp_valid), 0);
    repeat (3) cycle();
    check("desync_sticky", 32'(err_desync), 1);

    // Reset with three operations in flight.
    req_valid = 4'b1110;
    repeat (3) cycle();
    check("inflight_issue", 32'(mult_i_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mult_i_valid", 32'(mult_i_valid), 0);
    check("rst_mult_a", 32'(mult_a), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_err", 32'(err_desync), 0);
    exp_id.delete();
    exp_z.delete();
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (rsp_valid) seen++;
    end
    check("rst_no_stale", 32'(seen), 0);
    req_valid = 4'hF;
    #1;
    check("rst_first_grant", 32'(req_ready), 1);
    cycle();
    req_valid = 4'h0;
    repeat (8) cycle();
    check("rst_final_drain", 32'(exp_id.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
